// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one serial transmitter between byte-stream requesters.
// Define TX_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYC stalled SEND cycles (pulses frame_err).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active,
  output logic                 frame_err
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_cfg_chk
    $error("uart_tx_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {IDLE, SEND, STROBE, GAP} state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      last_grant, cand, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               found, last_q;
  logic               grant_ld, grant_clr, capture;
`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0]        stall_cnt;
  logic               timeout_hit;
`endif

  // last_grant doubles as the owner index while a grant is held
  always_comb begin
    pick_idx = last_grant;
    pick_oh  = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((32'(last_grant) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
    pick_oh[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    grant_ld  = 1'b0;
    grant_clr = 1'b0;
    capture   = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_ld = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (req_valid[last_grant] && !tx_busy) begin
          req_ready[last_grant] = 1'b1;
          capture               = 1'b1;
          state_nx              = STROBE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (!req_valid[last_grant] && stall_cnt == 16'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          grant_clr   = 1'b1;
          state_nx    = IDLE;
        end
`endif
      end
      STROBE: state_nx = GAP;
      GAP: begin
        if (last_q) begin
          grant_clr = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx = SEND;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      tx_data    <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      if (grant_ld) begin
        grant      <= pick_oh;
        last_grant <= pick_idx;
      end else if (grant_clr) begin
        grant <= '0;
      end
      if (capture) begin
        tx_data <= req_data[{last_grant, 3'b000} +: 8];
        last_q  <= req_last[last_grant];
      end
    end
  end

  assign new_tx_data = (state == STROBE);
  assign active      = |grant;

`ifdef TX_ARB_TIMEOUT_EN
  // Held at zero outside SEND so every entry into SEND starts a fresh count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout_hit;
      if (state != SEND || capture)        stall_cnt <= '0;
      else if (!req_valid[last_grant])     stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources, expected-byte queues popped on each strobe.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic [7:0]  tx_data;
  logic        new_tx_data, tx_busy, active, frame_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t      src_q0[$], src_q1[$];
  logic [7:0] exp_q0[$], exp_q1[$];
  int         strobe_cyc[$], strobe_own[$];
  logic [1:0] snap;

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .grant(grant), .active(active), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Requester model: a byte leaves its source queue only after req_ready was seen at the edge
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      #2 snap = req_ready;
      @(posedge clk);
      #1;
      if (snap[0] && src_q0.size() > 0) void'(src_q0.pop_front());
      if (snap[1] && src_q1.size() > 0) void'(src_q1.pop_front());
      if (src_q0.size() > 0) begin
        req_valid[0] = 1'b1; req_data[7:0] = src_q0[0].d; req_last[0] = src_q0[0].l;
      end else begin
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
      end
      if (src_q1.size() > 0) begin
        req_valid[1] = 1'b1; req_data[15:8] = src_q1[0].d; req_last[1] = src_q1[0].l;
      end else begin
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
      end
    end
  end

  // Output monitor: pops the owner's expected byte on every strobe
  initial begin
    int own;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (new_tx_data === 1'b1) begin
        own = (grant === 2'b10) ? 1 : 0;
        strobe_cyc.push_back(cyc);
        strobe_own.push_back(own);
        tests_run++;
        if (grant !== 2'b01 && grant !== 2'b10) begin
          tests_failed++;
          $display("FAIL strobe_grant: grant=%b required one-hot", grant);
        end
        tests_run++;
        if ((own == 0 && exp_q0.size() == 0) || (own == 1 && exp_q1.size() == 0)) begin
          tests_failed++;
          $display("FAIL strobe_unexpected: owner=%0d tx_data=%h required no strobe", own, tx_data);
        end else begin
          e = (own == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (tx_data !== e) begin
            tests_failed++;
            $display("FAIL strobe_data: owner=%0d tx_data=%h required %h", own, tx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int r, input logic [7:0] d, input logic l, input logic expect_out);
    beat_t b;
    b.d = d;
    b.l = l;
    if (r == 0) begin src_q0.push_back(b); if (expect_out) exp_q0.push_back(d); end
    else        begin src_q1.push_back(b); if (expect_out) exp_q1.push_back(d); end
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int b = 0;
    while (strobe_cyc.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    tests_run++;
    if (strobe_cyc.size() < n) begin
      tests_failed++;
      $display("FAIL %s_timeout: strobes=%0d required %0d", name, strobe_cyc.size(), n);
    end
  endtask

  task automatic clear_logs;
    repeat (4) @(negedge clk);
    strobe_cyc.delete();
    strobe_own.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tx_busy = 1'b0;
    push(0, 8'h10, 1'b1, 1'b1);
    push(1, 8'h20, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    tests_run++;
    if (grant !== 2'b00 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_grant: grant=%b active=%b required 00/0", grant, active);
    end
    tests_run++;
    if (new_tx_data !== 1'b0 || tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_tx: new_tx_data=%b tx_data=%h required 0/00", new_tx_data, tx_data);
    end
    tests_run++;
    if (req_ready !== 2'b00 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: req_ready=%b frame_err=%b required 00/0", req_ready, frame_err);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b01 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_grant: grant=%b active=%b required 01/1", grant, active);
    end
    wait_strobes(2, 30, "reset");
    tests_run++;
    if (strobe_own.size() < 2 || strobe_own[0] != 0 || strobe_own[1] != 1) begin
      tests_failed++;
      $display("FAIL reset_order: owners=%p required '{0,1}", strobe_own);
    end
    clear_logs();
  endtask

  task automatic test_single_frame;
    int k;
    @(negedge clk);
    k = cyc;
    push(0, 8'hB1, 1'b0, 1'b1);
    push(0, 8'h08, 1'b0, 1'b1);
    push(0, 8'h00, 1'b0, 1'b1);
    push(0, 8'h00, 1'b1, 1'b1);
    wait_strobes(4, 60, "single");
    if (strobe_cyc.size() >= 4) begin
      tests_run++;
      if (strobe_cyc[0] - k != 3) begin
        tests_failed++;
        $display("FAIL single_latency: first strobe %0d cycles after request, required 3", strobe_cyc[0] - k);
      end
      for (int i = 1; i < 4; i++) begin
        tests_run++;
        if (strobe_cyc[i] - strobe_cyc[i-1] != 3) begin
          tests_failed++;
          $display("FAIL single_spacing: strobe %0d gap=%0d required 3", i, strobe_cyc[i] - strobe_cyc[i-1]);
        end
      end
      while (cyc < strobe_cyc[3] + 2) @(negedge clk);
      tests_run++;
      if (grant !== 2'b00 || active !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_release: grant=%b active=%b required 00/0", grant, active);
      end
    end
    clear_logs();
  endtask

  task automatic test_round_robin;
    int exp_own[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 2; f++) begin
      push(0, 8'h68, 1'b0, 1'b1);
      push(0, 8'h69, 1'b1, 1'b1);
      push(1, 8'h31, 1'b0, 1'b1);
      push(1, 8'h32, 1'b1, 1'b1);
    end
    wait_strobes(8, 100, "rr");
    if (strobe_own.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (strobe_own[i] != exp_own[i]) begin
          tests_failed++;
          $display("FAIL rr_owner: byte %0d owner=%0d required %0d", i, strobe_own[i], exp_own[i]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_busy;
    int rdy_hits = 0;
    int rel;
    @(negedge clk);
    tx_busy = 1'b1;
    push(0, 8'h39, 1'b1, 1'b1);
    repeat (20) begin
      @(negedge clk);
      #1 if (req_ready !== 2'b00) rdy_hits++;
    end
    tests_run++;
    if (rdy_hits != 0 || strobe_cyc.size() != 0) begin
      tests_failed++;
      $display("FAIL busy_hold: ready_cycles=%0d strobes=%0d required 0/0", rdy_hits, strobe_cyc.size());
    end
    tests_run++;
    if (grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL busy_grant: grant=%b required 01", grant);
    end
    @(negedge clk);
    tx_busy = 1'b0;
    rel = cyc;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL busy_release_ready: req_ready=%b required 01", req_ready);
    end
    wait_strobes(1, 10, "busy");
    if (strobe_cyc.size() >= 1) begin
      tests_run++;
      if (strobe_cyc[0] != rel + 1) begin
        tests_failed++;
        $display("FAIL busy_strobe_cycle: cycle=%0d required %0d", strobe_cyc[0], rel + 1);
      end
    end
    repeat (6) @(negedge clk);
    tests_run++;
    if (strobe_cyc.size() != 1 || tx_data !== 8'h39 || grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL busy_after: strobes=%0d tx_data=%h grant=%b required 1/39/00",
               strobe_cyc.size(), tx_data, grant);
    end
    clear_logs();
  endtask

  task automatic test_stall;
    int bad_grant = 0;
    int rdy1      = 0;
    int errs      = 0;
    push(0, 8'hAA, 1'b0, 1'b1);
    wait_strobes(1, 20, "stall");
`ifdef TX_ARB_TIMEOUT_EN
    push(1, 8'h55, 1'b1, 1'b1);
    repeat (60) begin
      @(negedge clk);
      if (frame_err === 1'b1) errs++;
    end
    tests_run++;
    if (errs != 1) begin
      tests_failed++;
      $display("FAIL timeout_pulses: frame_err pulses=%0d required 1", errs);
    end
    tests_run++;
    if (strobe_own.size() != 2 || strobe_own[1] != 1 || grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL timeout_handover: strobes=%0d grant=%b required 2 strobes, second from 1, grant 00",
               strobe_own.size(), grant);
    end
`else
    push(1, 8'h55, 1'b1, 1'b0);
    repeat (40) begin
      @(negedge clk);
      #1;
      if (grant !== 2'b01) bad_grant++;
      if (req_ready[1] !== 1'b0) rdy1++;
      if (frame_err !== 1'b0) errs++;
    end
    tests_run++;
    if (bad_grant != 0 || rdy1 != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: cycles_not_01=%0d ready1_cycles=%0d required 0/0", bad_grant, rdy1);
    end
    tests_run++;
    if (strobe_cyc.size() != 1 || errs != 0 || active !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_state: strobes=%0d frame_err_cycles=%0d active=%b required 1/0/1",
               strobe_cyc.size(), errs, active);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_busy();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single serial transmitter (tx_data / new_tx_data / tx_busy handshake) between up to NUM_REQ byte-stream requesters, e.g. the message printer and the matrix-result streamer.
- Arbitration is round-robin at frame granularity: once granted, a requester keeps the transmitter until it presents a byte flagged last.
- Sits between the requesters and the serial_tx instance in the top level.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- TIMEOUT_CYC, 256, idle cycles allowed mid-frame before the grant is revoked (used only with the optional feature; legal range 2..65535).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on its slice of req_data.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i ends its frame.
- req_ready  out  NUM_REQ  combinational; byte of requester i consumed this cycle.
- tx_data  out  8  registered byte to the transmitter.
- new_tx_data  out  1  one-cycle strobe; tx_data valid.
- tx_busy  in  1  transmitter busy.
- grant  out  NUM_REQ  registered one-hot owner; all-zero when idle.
- active  out  1  high while any grant is held.
- frame_err  out  1  one-cycle pulse on timeout revoke (tied 0 without the optional feature).

Behaviour:
- Reset (rst low, asynchronous):
  - State → IDLE.
  - grant = 0, active = 0, tx_data = 8'h00, new_tx_data = 0, frame_err = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-frame drops any in-flight byte without a strobe.
- States: IDLE, SEND, STROBE, GAP.
- IDLE:
  - If any req_valid is high, choose the first set bit searching from last_grant+1 upward, with wrap-around.
  - Register the choice in grant (one-hot), set active = 1 and last_grant = index, then go to SEND.
  - If no req_valid is high, stay in IDLE.
  - req_ready = 0 in IDLE.
- SEND:
  - When req_valid[g] is high and tx_busy is low, req_ready[g] = 1 combinationally in that cycle.
  - In the same cycle, capture tx_data ← req_data slice g and latch last ← req_last[g], then go to STROBE.
  - Otherwise hold, with req_ready = 0.
  - req_ready for non-granted requesters is always 0.
- STROBE: new_tx_data = 1 for exactly this cycle, with tx_data stable; go to GAP.
- GAP (one cycle, tx_busy ignored, covers the transmitter's busy-rise latency):
  - If the latched last is 1: grant = 0, active = 0, go to IDLE.
  - Otherwise go to SEND.
- Latency:
  - req_valid rising in IDLE with tx_busy low: grant at cycle +1, req_ready at cycle +1, new_tx_data at cycle +2.
  - Back-to-back bytes of one frame: at most one byte per 3 cycles, further throttled by tx_busy.
- tx_data holds its value until the next capture; it is not cleared after the strobe.
- A requester dropping req_valid mid-frame stalls the arbiter in SEND. Other requesters are not served until the frame ends (or until a timeout, with the optional feature).
- Simultaneous events:
  - A new req_valid arriving during GAP with last = 1 is evaluated in IDLE on the next cycle; there is no same-cycle regrant.
  - A single-byte frame (req_last = 1 on its first byte) is legal.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to SEND and on every accepted byte, and increments each SEND cycle in which req_valid[g] is low.
  - When the counter reaches TIMEOUT_CYC-1: pulse frame_err for one cycle, clear grant and active, go to IDLE.
  - last_grant keeps the revoked index, so the next arbitration starts after it.
- When undefined: no counter, frame_err is tied 0, and SEND waits indefinitely.

Test Plan:
- Reset state: hold rst low, drive req_valid = 2'b11 → grant = 0, new_tx_data = 0, tx_data = 8'h00. Release rst → grant = 2'b01 one cycle later.
- Single frame: requester 0 sends 8'hB1, 8'h08, 8'h00, 8'h00 (last on the fourth byte), tx_busy low → four new_tx_data strobes carrying B1, 08, 00, 00 in order, 3 cycles apart; grant returns to 0 after the fourth GAP.
- Round-robin: both requesters valid continuously with 2-byte frames (8'h68/8'h69 and 8'h31/8'h32) → frames alternate 0, 1, 0, 1; no byte of one frame is interleaved into another.
- Busy backpressure: requester 0 valid with 8'h39; hold tx_busy high for 20 cycles, then release → req_ready and capture occur only on the first cycle tx_busy is low; exactly one strobe.
- Mid-frame stall: requester 0 sends 8'hAA (not last) then drops valid while requester 1 is valid → requester 1 is never granted while requester 0 holds the grant; without TX_ARB_TIMEOUT_EN, grant = 2'b01 remains.
- Timeout (TX_ARB_TIMEOUT_EN, TIMEOUT_CYC = 16): same stimulus → frame_err pulses once 16 SEND cycles after the stall, grant moves to 2'b10 two cycles later, and requester 1's byte is strobed.
